branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_pkg.sv | 39 +++
 rtl/branch_cond_eval.sv | 37 +++
 rtl/branch_unit.sv | 121 ++++++++++++
 tb/tb_branch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch unit: operation codes, condition codes and the
// architectural flags word.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_CMP = 2'd1,
    OP_SUB = 2'd2,
    OP_JF  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    C_EQ     = 4'd0,
    C_NE     = 4'd1,
    C_GT     = 4'd2,
    C_LT     = 4'd3,
    C_RDZ    = 4'd4,
    C_RDNEG  = 4'd5,
    C_RDONES = 4'd6,
    C_NEVER7 = 4'd7,
    C_GTU    = 4'd8,
    C_LTU    = 4'd9,
    C_GE     = 4'd10,
    C_LE     = 4'd11,
    C_GEU    = 4'd12,
    C_LEU    = 4'd13,
    C_ALWAYS = 4'd14,
    C_NEVER  = 4'd15
  } cond_e;

  // Packed so that bit 3 is Z and bit 0 is V on the external flags port.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator shared by CMP (fresh flags) and JF
// (stored flags). Codes 4-6 look at rd_data directly rather than the flags.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  flags_t           flags,
  input  cond_e            cond,
  input  logic [WIDTH-1:0] rd_data,
  output logic             jump
);

  always_comb begin
    jump = 1'b0;
    case (cond)
      C_EQ:     jump = flags.z;
      C_NE:     jump = !flags.z;
      C_GT:     jump = !flags.z && (flags.n == flags.v);
      C_LT:     jump = (flags.n != flags.v);
      C_RDZ:    jump = (rd_data == '0);
      C_RDNEG:  jump = rd_data[WIDTH-1];
      C_RDONES: jump = (rd_data == '1);
      C_NEVER7: jump = 1'b0;
      C_GTU:    jump = flags.c && !flags.z;
      C_LTU:    jump = !flags.c;
      C_GE:     jump = (flags.n == flags.v);
      C_LE:     jump = flags.z || (flags.n != flags.v);
      C_GEU:    jump = flags.c;
      C_LEU:    jump = !flags.c || flags.z;
      C_ALWAYS: jump = 1'b1;
      C_NEVER:  jump = 1'b0;
      default:  jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch decision unit: compare/subtract flag generation, flag register,
// single-entry output register with valid/ready handshake, taken counter.
module branch_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [3:0]       cond,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] alu_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             jump,
  output logic [3:0]       flags,
  output logic             flags_valid,
  output logic [CNT_W-1:0] taken_cnt
);

  op_e              op_sel;
  cond_e            cond_sel;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] diff;
  flags_t           cmp_flags;
  flags_t           sub_flags;
  flags_t           flags_q;
  flags_t           eval_flags;
  logic             eval_jump;
  logic             jump_next;
  logic             accept;
  logic             handshake;

  assign op_sel   = op_e'(op);
  assign cond_sel = cond_e'(cond);

  // rd - B as rd + ~B + 1; bit WIDTH is the carry (1 = no borrow).
  assign b_op     = use_imm ? imm : rs_data;
  assign diff_ext = {1'b0, rd_data} + {1'b0, ~b_op} + {{WIDTH{1'b0}}, 1'b1};
  assign diff     = diff_ext[WIDTH-1:0];

  assign cmp_flags.z = (diff == '0);
  assign cmp_flags.n = diff[WIDTH-1];
  assign cmp_flags.c = diff_ext[WIDTH];
  assign cmp_flags.v = (rd_data[WIDTH-1] != b_op[WIDTH-1]) &&
                       (diff[WIDTH-1] != rd_data[WIDTH-1]);

  assign sub_flags.z = (alu_out == '0);
  assign sub_flags.n = alu_out[WIDTH-1];
  assign sub_flags.c = 1'b0;
  assign sub_flags.v = 1'b0;

  // CMP decides on its own fresh flags; JF on whatever the register holds.
  assign eval_flags = (op_sel == OP_CMP) ? cmp_flags : flags_q;

  branch_cond_eval #(
    .WIDTH (WIDTH)
  ) u_cond_eval (
    .flags   (eval_flags),
    .cond    (cond_sel),
    .rd_data (rd_data),
    .jump    (eval_jump)
  );

  always_comb begin
    jump_next = 1'b0;
    case (op_sel)
      OP_CMP:  jump_next = eval_jump;
      OP_SUB:  jump_next = sub_flags.z;
      OP_JF:   jump_next = flags_valid && eval_jump;
      default: jump_next = 1'b0;
    endcase
  end

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      jump        <= 1'b0;
      flags_q     <= '0;
      flags_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        jump      <= jump_next;
        if (op_sel == OP_CMP) begin
          flags_q     <= cmp_flags;
          flags_valid <= 1'b1;
        end else if (op_sel == OP_SUB) begin
          flags_q     <= sub_flags;
          flags_valid <= 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Counts the result being delivered, not the one being loaded this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt <= '0;
    end else if (handshake && jump && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign flags = flags_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a 16-bit counter instance and a 2-bit
// counter instance share all stimulus; expected jumps queue at acceptance.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [3:0]  cond = 4'd0;
  logic        use_imm = 1'b0;
  logic [15:0] rd_data = '0, rs_data = '0, imm = '0, alu_out = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, jump, flags_valid;
  logic [3:0]  flags;
  logic [15:0] taken_cnt;
  logic        in_ready2, out_valid2, jump2, flags_valid2;
  logic [3:0]  flags2;
  logic [1:0]  taken_cnt2;

  always #5 clk = ~clk;

  branch_unit #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cond(cond), .use_imm(use_imm), .rd_data(rd_data),
    .rs_data(rs_data), .imm(imm), .alu_out(alu_out), .out_valid(out_valid),
    .out_ready(out_ready), .jump(jump), .flags(flags),
    .flags_valid(flags_valid), .taken_cnt(taken_cnt));

  branch_unit #(.WIDTH(16), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .cond(cond), .use_imm(use_imm), .rd_data(rd_data),
    .rs_data(rs_data), .imm(imm), .alu_out(alu_out), .out_valid(out_valid2),
    .out_ready(out_ready), .jump(jump2), .flags(flags2),
    .flags_valid(flags_valid2), .taken_cnt(taken_cnt2));

  int          n_vec = 0;
  int          n_err = 0;
  logic        exp_q[$];
  logic        m_ov = 1'b0;
  logic [3:0]  m_flags = '0;
  logic        m_fv = 1'b0;
  logic [15:0] m_cnt16 = '0;
  logic [1:0]  m_cnt2 = '0;
  logic        last_acc = 1'b0;
  logic        rst_done = 1'b0;

  // Reference for CMP: conditions straight from integer comparisons.
  function automatic logic cmp_exp(input logic [3:0] c, input logic [15:0] a,
                                   input logic [15:0] b);
    case (c)
      4'd0:  return a == b;
      4'd1:  return a != b;
      4'd2:  return $signed(a) > $signed(b);
      4'd3:  return $signed(a) < $signed(b);
      4'd4:  return a == 16'h0000;
      4'd5:  return a[15];
      4'd6:  return a == 16'hFFFF;
      4'd8:  return a > b;
      4'd9:  return a < b;
      4'd10: return $signed(a) >= $signed(b);
      4'd11: return $signed(a) <= $signed(b);
      4'd12: return a >= b;
      4'd13: return a <= b;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic flag_exp(input logic [3:0] c, input logic [3:0] f,
                                    input logic [15:0] a);
    logic z, n, cy, v;
    {z, n, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return !z && (n == v);
      4'd3:  return n != v;
      4'd4:  return a == 16'h0000;
      4'd5:  return a[15];
      4'd6:  return a == 16'hFFFF;
      4'd8:  return cy && !z;
      4'd9:  return !cy;
      4'd10: return n == v;
      4'd11: return z || (n != v);
      4'd12: return cy;
      4'd13: return !cy || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    logic acc, hs, jx, head;
    logic [15:0] b, d;
    #1;
    n_vec++;
    if (in_ready !== (!m_ov || out_ready)) begin
      n_err++;
      $display("FAIL in_ready: got %b expected %b", in_ready, !m_ov || out_ready);
    end
    n_vec++;
    if (in_ready2 !== (!m_ov || out_ready)) begin
      n_err++;
      $display("FAIL in_ready_sat: got %b expected %b", in_ready2, !m_ov || out_ready);
    end
    acc = in_valid && (!m_ov || out_ready);
    hs  = m_ov && out_ready;
    last_acc = acc && !reset;
    rst_done = reset;
    if (reset) begin
      exp_q.delete();
      m_ov = 1'b0; m_flags = '0; m_fv = 1'b0; m_cnt16 = '0; m_cnt2 = '0;
    end else begin
      if (hs) begin
        head = exp_q.pop_front();
        if (head) begin
          if (m_cnt16 != 16'hFFFF) m_cnt16++;
          if (m_cnt2 != 2'd3) m_cnt2++;
        end
      end
      if (acc) begin
        b = use_imm ? imm : rs_data;
        d = rd_data - b;
        jx = 1'b0;
        case (op)
          2'd1: begin
            jx = cmp_exp(cond, rd_data, b);
            m_flags = {d == 16'h0, d[15], rd_data >= b,
                       ($signed(rd_data) < $signed(b)) != d[15]};
            m_fv = 1'b1;
          end
          2'd2: begin
            jx = (alu_out == 16'h0);
            m_flags = {alu_out == 16'h0, alu_out[15], 2'b00};
            m_fv = 1'b1;
          end
          2'd3: jx = m_fv && flag_exp(cond, m_flags, rd_data);
          default: jx = 1'b0;
        endcase
        exp_q.push_back(jx);
        m_ov = 1'b1;
      end else if (hs) begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== m_ov || out_valid2 !== m_ov) begin
      n_err++;
      $display("FAIL out_valid: got %b/%b expected %b", out_valid, out_valid2, m_ov);
    end
    if (m_ov && exp_q.size() > 0) begin
      n_vec++;
      if (jump !== exp_q[0] || jump2 !== exp_q[0]) begin
        n_err++;
        $display("FAIL jump: got %b/%b expected %b", jump, jump2, exp_q[0]);
      end
    end
    if (rst_done) begin
      n_vec++;
      if (jump !== 1'b0) begin
        n_err++;
        $display("FAIL reset_jump: got %b expected 0", jump);
      end
    end
    n_vec++;
    if (flags !== m_flags || flags2 !== m_flags) begin
      n_err++;
      $display("FAIL flags: got %b/%b expected %b", flags, flags2, m_flags);
    end
    n_vec++;
    if (flags_valid !== m_fv || flags_valid2 !== m_fv) begin
      n_err++;
      $display("FAIL flags_valid: got %b/%b expected %b", flags_valid, flags_valid2, m_fv);
    end
    n_vec++;
    if (taken_cnt !== m_cnt16) begin
      n_err++;
      $display("FAIL taken_cnt: got %0d expected %0d", taken_cnt, m_cnt16);
    end
    n_vec++;
    if (taken_cnt2 !== m_cnt2) begin
      n_err++;
      $display("FAIL taken_cnt_sat: got %0d expected %0d", taken_cnt2, m_cnt2);
    end
  endtask

  task automatic req(input logic [1:0] o, input logic [3:0] c, input logic ui,
                     input logic [15:0] rd, input logic [15:0] rs,
                     input logic [15:0] im, input logic [15:0] alu);
    op = o; cond = c; use_imm = ui; rd_data = rd; rs_data = rs; imm = im;
    alu_out = alu; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout: request op %0d not accepted in 20 cycles", o);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; out_ready = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_cmp_gt();
    req(2'd1, 4'd2, 1'b0, 16'h0005, 16'h0003, 16'h0, 16'h0);
    idle(1);
    n_vec++;
    if (flags !== 4'b0010) begin
      n_err++;
      $display("FAIL cmp_gt_flags: got %b expected 0010", flags);
    end
  endtask

  task automatic test_imm();
    req(2'd1, 4'd3, 1'b1, 16'hFFFF, 16'h1234, 16'h0001, 16'h0);
    req(2'd1, 4'd9, 1'b1, 16'hFFFF, 16'h1234, 16'h0001, 16'h0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    req(2'd1, 4'd0, 1'b0, 16'h8000, 16'h0001, 16'h0, 16'h0);
    req(2'd3, 4'd3, 1'b0, 16'h0000, 16'h0, 16'h0, 16'h0);
    n_vec++;
    if (flags !== 4'b0011 || jump !== 1'b1) begin
      n_err++;
      $display("FAIL jf_forward: got flags %b jump %b expected 0011 1", flags, jump);
    end
    idle(1);
  endtask

  task automatic test_stall();
    req(2'd1, 4'd1, 1'b0, 16'h0010, 16'h0020, 16'h0, 16'h0);
    out_ready = 1'b0;
    op = 2'd1; cond = 4'd0; rd_data = 16'h0007; rs_data = 16'h0007;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (last_acc) begin
        n_err++;
        $display("FAIL stall_accept: got accepted expected held at cycle %0d", i);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (!last_acc) begin
      n_err++;
      $display("FAIL stall_release: got not accepted expected accepted");
    end
    idle(2);
  endtask

  task automatic test_sub_reset();
    req(2'd2, 4'd1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0000);
    idle(1);
    out_ready = 1'b0;
    req(2'd0, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    idle(1);
    req(2'd3, 4'd14, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    idle(1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 5; i++)
      req(2'd1, 4'd14, 1'b0, 16'h1111, 16'h2222, 16'h0, 16'h0);
    idle(2);
    n_vec++;
    if (taken_cnt2 !== 2'd3) begin
      n_err++;
      $display("FAIL saturate: got %0d expected 3", taken_cnt2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      cond = 4'($urandom_range(0, 15));
      use_imm = 1'($urandom_range(0, 1));
      rd_data = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      rs_data = ($urandom_range(0, 3) == 0) ? rd_data : 16'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? rd_data : 16'($urandom);
      alu_out = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    out_ready = 1'b1;
    idle(2);
  endtask

  initial begin
    test_reset();
    test_cmp_gt();
    test_imm();
    test_back_to_back();
    test_stall();
    test_sub_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
